traffic_sensor_conditioner: RTL and testbench

Front-end conditioning stage for the two-road traffic light controller. It takes the raw vehicle-detector inputs for road A and road B, then synchronises, debounces and applies a minimum-presence hold to each. It drives the controller's `Ta` / `Tb` traffic-present inputs (1 = traffic present) and exports the shared 1 s tick. It sits directly upstream of the controller, on the same clock.

---
 rtl/traffic_pkg.sv | 20 ++
 rtl/sensor_channel.sv | 70 +++++++
 rtl/traffic_sensor_conditioner.sv | 60 ++++++
 tb/tb_traffic_sensor_conditioner.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared traffic-controller constants: light encodings, default tick rate, presence polarity.
package traffic_pkg;

  typedef logic [1:0] light_t;

  localparam light_t GREEN  = 2'd0;
  localparam light_t YELLOW = 2'd1;
  localparam light_t RED    = 2'd2;

  localparam int unsigned CLK_FREQ_HZ = 12_000_000;

  localparam logic TRAFFIC_PRESENT = 1'b1;
  localparam logic TRAFFIC_ABSENT  = 1'b0;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sensor_channel.sv
// One detector channel: 2-FF synchroniser, debouncer and optional minimum-presence hold.
// Hold stage is built only when TRAFFIC_SENSOR_HOLD_EN is defined.
module sensor_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned HOLD_TICKS      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sec_tick,
  input  logic raw,
  output logic T
);

  localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DCNT_MAX = DW'(DEBOUNCE_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic [DW-1:0] r_dcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1   <= TRAFFIC_ABSENT;
      r_s2   <= TRAFFIC_ABSENT;
      r_deb  <= TRAFFIC_ABSENT;
      r_dcnt <= '0;
    end else begin
      r_s1 <= raw;
      r_s2 <= r_s1;
      // Any sample agreeing with the accepted level restarts the stability count.
      if (r_s2 == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCNT_MAX) begin
        r_deb  <= r_s2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + 1'b1;
      end
    end
  end

`ifdef TRAFFIC_SENSOR_HOLD_EN
  localparam int unsigned HW = cnt_width(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  logic [HW-1:0] r_hcnt;

  // Reloaded while present, so a fall coinciding with a tick does not count that tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hcnt <= '0;
    end else if (r_deb == TRAFFIC_PRESENT) begin
      r_hcnt <= HOLD_LOAD;
    end else if (sec_tick && (r_hcnt != '0)) begin
      r_hcnt <= r_hcnt - 1'b1;
    end
  end

  assign T = r_deb | (r_hcnt != '0);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = sec_tick ^ (HOLD_TICKS > 0);

  assign T = r_deb;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Conditions road A/B detector inputs into Ta/Tb and exports the shared second tick.
// Minimum-presence hold is enabled by defining TRAFFIC_SENSOR_HOLD_EN.
module traffic_sensor_conditioner
  import traffic_pkg::*;
#(
  parameter int unsigned CLK_DIV         = CLK_FREQ_HZ,
  parameter int unsigned DEBOUNCE_CYCLES = 120_000,
  parameter int unsigned HOLD_TICKS      = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_a,
  input  logic raw_b,
  output logic Ta,
  output logic Tb,
  output logic sec_tick
);

  localparam int unsigned PW = cnt_width(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc <= '0;
    end else if (r_presc == PRESC_MAX) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  assign w_tick   = (r_presc == PRESC_MAX);
  assign sec_tick = w_tick;

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_TICKS      (HOLD_TICKS)
  ) u_chan_a (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (w_tick),
    .raw      (raw_a),
    .T        (Ta)
  );

  sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .HOLD_TICKS      (HOLD_TICKS)
  ) u_chan_b (
    .clk      (clk),
    .reset    (reset),
    .sec_tick (w_tick),
    .raw      (raw_b),
    .T        (Tb)
  );

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Directed bench for traffic_sensor_conditioner with CLK_DIV=10, DEBOUNCE_CYCLES=4, HOLD_TICKS=3.
// Hold expectations follow TRAFFIC_SENSOR_HOLD_EN when it is defined for the build.
module tb_traffic_sensor_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic raw_a;
  logic raw_b;
  logic Ta;
  logic Tb;
  logic sec_tick;

  int checks = 0;
  int errors = 0;
  int e_cnt  = 0;

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .CLK_DIV         (10),
    .DEBOUNCE_CYCLES (4),
    .HOLD_TICKS      (3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .raw_a    (raw_a),
    .raw_b    (raw_b),
    .Ta       (Ta),
    .Tb       (Tb),
    .sec_tick (sec_tick)
  );

  typedef struct {
    logic rst;
    logic ra;
    logic rb;
    logic ta;
    logic tb;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b (edges since reset %0d)", name, act, exp, e_cnt);
    end
  endtask

  // One clock edge; the tick is expected in the tenth cycle of every second after reset.
  task automatic step(input logic rst, input logic ra, input logic rb);
    reset = rst;
    raw_a = ra;
    raw_b = rb;
    @(posedge clk);
    #1;
    if (rst) e_cnt = 0;
    else     e_cnt++;
    chk("sec_tick", sec_tick, (e_cnt % 10) == 9);
  endtask

  // Drop raw_a with Ta high; deb falls after the 6th edge, hcnt then counts ticks seen with deb low.
  task automatic drop_and_wait(input int stop_decs, input int max_k);
    int   decs;
    bit   reached;
    logic exp;
    decs    = 0;
    reached = 1'b0;
    for (int k = 0; k < max_k; k++) begin
      step(1'b0, 1'b0, 1'b0);
      if (k > 5 && (e_cnt % 10) == 0) decs++;
`ifdef TRAFFIC_SENSOR_HOLD_EN
      exp = (k <= 5) || (decs < 3);
`else
      exp = (k < 5);
`endif
      chk("hold_ta", Ta, exp);
      chk("hold_tb", Tb, 1'b0);
      if (stop_decs >= 0 && k > 5 && decs == stop_decs) begin
        reached = 1'b1;
        break;
      end
    end
    if (stop_decs >= 0) chk("hold_wait", reached, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    raw_a = 1'b1;
    raw_b = 1'b1;

    for (int i = 0; i < 3; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    // raw_a rises before edge 0 -> Ta after edge 5; raw_b 3-cycle glitch.
    for (int r = 0; r < 6; r++) vecs[3 + r] = '{1'b0, 1'b1, logic'(r < 3), logic'(r == 5), 1'b0};
    // Repeated 3-on/1-off on raw_b never settles.
    for (int j = 0; j < 12; j++) vecs[9 + j] = '{1'b0, 1'b1, logic'((j % 4) != 3), 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].rst, vecs[i].ra, vecs[i].rb);
      chk($sformatf("vec%0d_ta", i), Ta, vecs[i].ta);
      chk($sformatf("vec%0d_tb", i), Tb, vecs[i].tb);
    end

    // Full hold, then raw_a back for a fresh rise.
    drop_and_wait(-1, 40);
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("rise_again_ta", Ta, k >= 5);
    end

    // Reset while present drops Ta on the reset edge.
    step(1'b1, 1'b0, 1'b0);
    chk("rst_mid_ta", Ta, 1'b0);
    chk("rst_mid_tb", Tb, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("after_rst_ta", Ta, 1'b0);
    end

`ifdef TRAFFIC_SENSOR_HOLD_EN
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("rise3_ta", Ta, k >= 5);
    end
    // Re-presence after one tick of hold keeps Ta continuously high.
    drop_and_wait(1, 40);
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("repres_ta", Ta, 1'b1);
    end
    // Reset with hcnt == 2 abandons the hold.
    drop_and_wait(1, 40);
    step(1'b1, 1'b0, 1'b0);
    chk("rst_hold_ta", Ta, 1'b0);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b0, 1'b0);
      chk("rst_hold_after_ta", Ta, 1'b0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
